// File: rtl/pipe_skid_reg_pkg.sv
// ============================================================================
// Module      : pipe_skid_reg_pkg
// Description : Shared DSP definitions for the skid-buffer pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_skid_reg_pkg;

  localparam int unsigned C_DEFAULT_LENGTH = 18;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage : pipe_skid_reg_pkg

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Valid/ready pipeline stage; registered skid buffer or bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned LENGTH  = C_DEFAULT_LENGTH,
  parameter bit          USE_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data
);

  generate
    if (USE_REG) begin : g_reg
      skid_state_e       r_state;
      skid_state_e       w_state_nxt;
      logic [LENGTH-1:0] r_main;
      logic [LENGTH-1:0] w_main_nxt;
      logic [LENGTH-1:0] r_skid;
      logic [LENGTH-1:0] w_skid_nxt;
      logic              w_in_xfer;
      logic              w_out_xfer;

      // in_ready depends only on registered state, never on out_ready;
      // it is also held low while reset is asserted.
      assign in_ready   = (r_state != ST_FULL) & clk_en & rst_n;
      assign out_valid  = (r_state != ST_EMPTY) & clk_en;
      assign out_data   = r_main;

      assign w_in_xfer  = in_valid & in_ready;
      assign w_out_xfer = out_valid & out_ready;

      always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              w_main_nxt  = in_data;
              w_state_nxt = ST_BUSY;
            end
          end
          ST_BUSY: begin
            case ({w_in_xfer, w_out_xfer})
              2'b11: w_main_nxt = in_data;
              2'b10: begin
                w_skid_nxt  = in_data;
                w_state_nxt = ST_FULL;
              end
              2'b01: w_state_nxt = ST_EMPTY;
              default: ;
            endcase
          end
          ST_FULL: begin
            if (w_out_xfer) begin
              w_main_nxt  = r_skid;
              w_state_nxt = ST_BUSY;
            end
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end

      // With clk_en low both handshakes are forced low, so the hold path
      // above already freezes every register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
          r_main  <= '0;
          r_skid  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_main  <= w_main_nxt;
          r_skid  <= w_skid_nxt;
        end
      end
    end else begin : g_bypass
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
    end
  endgenerate

endmodule : pipe_skid_reg

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg (registered and bypass).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  localparam int unsigned C_W = 18;

  logic           clk;
  logic           rst_n;
  logic           clk_en;
  logic           in_valid;
  logic           in_ready;
  logic [C_W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [C_W-1:0] out_data;

  logic           b_in_valid;
  logic           b_in_ready;
  logic [C_W-1:0] b_in_data;
  logic           b_out_valid;
  logic           b_out_ready;
  logic [C_W-1:0] b_out_data;

  pipe_skid_reg #(.LENGTH(C_W), .USE_REG(1'b1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  pipe_skid_reg #(.LENGTH(C_W), .USE_REG(1'b0)) u_byp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the stage is a FIFO of at most two words; out_data
  // shows the oldest held word, or the last word to leave once empty.
  logic [C_W-1:0] mq[$];
  logic [C_W-1:0] m_last;
  logic           pend_ix;
  logic           pend_ox;
  logic [C_W-1:0] pend_d;
  logic [C_W-1:0] txq[$];
  logic [C_W-1:0] rxq[$];

  typedef struct {
    logic           v;
    logic [C_W-1:0] d;
    logic           ordy;
    logic           en;
    logic           e_ov;
    logic           e_ir;
    logic           e_chkd;
    logic [C_W-1:0] e_od;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic v, input logic [C_W-1:0] d,
                              input logic ordy, input logic en,
                              input logic e_ov, input logic e_ir,
                              input logic e_chkd, input logic [C_W-1:0] e_od);
    vec_t r;
    r.v = v; r.d = d; r.ordy = ordy; r.en = en;
    r.e_ov = e_ov; r.e_ir = e_ir; r.e_chkd = e_chkd; r.e_od = e_od;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply inputs, let them settle, compare against the model and record
  // which handshakes the model expects at the coming edge.
  task automatic drive(input logic v, input logic [C_W-1:0] d,
                       input logic ordy, input logic en);
    logic exp_ov;
    logic exp_ir;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clk_en    = en;
    #1;
    exp_ov = (mq.size() != 0) && en;
    exp_ir = (mq.size() < 2) && en;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    if (exp_ov) chk("out_data", {14'd0, out_data}, {14'd0, mq[0]});
    if (out_valid && out_ready) rxq.push_back(out_data);
    pend_ix = v && exp_ir;
    pend_ox = exp_ov && ordy;
    pend_d  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    if (pend_ox) m_last = mq.pop_front();
    if (pend_ix) mq.push_back(pend_d);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
  endtask

  initial begin
    int             sent;
    int             cycles;
    logic [C_W-1:0] cur;
    logic           rv;
    logic           rr;
    logic           ren;

    // Streaming 1..8, backpressure 5/6/7, then enable freeze on a full stage.
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1'b1, C_W'(i + 1), 1'b1, 1'b1, (i != 0), 1'b1, (i != 0), C_W'(i));
    tbl[8]  = mk(1'b0, 18'h0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd8);
    tbl[9]  = mk(1'b1, 18'd5,     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0);
    tbl[10] = mk(1'b1, 18'd6,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'd5);
    tbl[11] = mk(1'b1, 18'd7,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 18'd5);
    tbl[12] = mk(1'b1, 18'd7,     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 18'd5);
    tbl[13] = mk(1'b1, 18'd7,     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd6);
    tbl[14] = mk(1'b0, 18'h0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd7);
    tbl[15] = mk(1'b1, 18'h3FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0);
    tbl[16] = mk(1'b1, 18'h00001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 18'h3FFFF);
    for (int i = 17; i < 21; i++)
      tbl[i] = mk(1'b0, 18'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h3FFFF);
    tbl[21] = mk(1'b0, 18'h0,     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h3FFFF);
    tbl[22] = mk(1'b0, 18'h0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h00001);
    tbl[23] = mk(1'b0, 18'h0,     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 18'h00001);

    rst_n = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    pend_ix = 1'b0; pend_ox = 1'b0; pend_d = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", {14'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].en);
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
      if (tbl[i].e_chkd)
        chk($sformatf("tbl%0d_out_data", i), {14'd0, out_data}, {14'd0, tbl[i].e_od});
      tick();
    end

    // Reset while FULL, asserted between edges.
    drive(1'b1, 18'h0AAAA, 1'b0, 1'b1); tick();
    drive(1'b1, 18'h15555, 1'b0, 1'b1); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {14'd0, out_data}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 18'h2ABCD, 1'b1, 1'b1); tick();
    chk("postrst_first_word", {14'd0, out_data}, 32'h2ABCD);
    drive(1'b0, 18'h0, 1'b1, 1'b1); tick();
    drive(1'b0, 18'h0, 1'b1, 1'b1); tick();

    // Random stalls against the model and an order scoreboard.
    txq.delete();
    rxq.delete();
    sent   = 0;
    cycles = 0;
    cur    = C_W'($urandom);
    while (sent < 1000 && cycles < 20000) begin
      rv  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      ren = ($urandom_range(0, 7) != 0);
      drive(rv, cur, rr, ren);
      tick();
      if (pend_ix) begin
        txq.push_back(cur);
        sent++;
        cur = C_W'($urandom);
      end
      cycles++;
    end
    chk("random_all_sent", {31'd0, (sent >= 1000)}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 18'h0, 1'b1, 1'b1);
      tick();
    end
    chk("random_count", rxq.size(), txq.size());
    for (int i = 0; i < txq.size() && i < rxq.size(); i++)
      if (rxq[i] !== txq[i]) chk($sformatf("random_word%0d", i), {14'd0, rxq[i]}, {14'd0, txq[i]});
    checks++;

    // Combinational bypass.
    b_in_valid = 1'b1; b_in_data = 18'h12345; b_out_ready = 1'b0;
    #1;
    chk("byp_out_data", {14'd0, b_out_data}, 32'h12345);
    chk("byp_out_valid", {31'd0, b_out_valid}, 32'd1);
    chk("byp_in_ready", {31'd0, b_in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = C_W'($urandom);
      #1;
      chk("byp_rand_valid", {31'd0, b_out_valid}, {31'd0, b_in_valid});
      chk("byp_rand_ready", {31'd0, b_in_ready}, {31'd0, b_out_ready});
      chk("byp_rand_data", {14'd0, b_out_data}, {14'd0, b_in_data});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_skid_reg

`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter LENGTH, default 18, giving the data width in bits.
REQ-002 SHALL have parameter USE_REG, default 1; 1 selects a registered skid stage, 0 selects a combinational pass-through.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk_en, input, 1 bit: stage enable; when low, the stage is frozen.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-007 SHALL have port in_ready, output, 1 bit: stage can accept data.
REQ-008 SHALL have port in_data, input, LENGTH bits: upstream data.
REQ-009 SHALL have port out_valid, output, 1 bit: downstream data valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts data.
REQ-011 SHALL have port out_data, output, LENGTH bits: downstream data.

Function
REQ-012 SHALL count a transfer on a side only at a rising clk edge where valid=1, ready=1 and clk_en=1.
REQ-013 SHALL hold a main register, a skid register and a 2-bit state: EMPTY (0 words held), BUSY (main holds 1 word), FULL (main and skid hold 1 word each).
REQ-014 SHALL drive out_valid = (state!=EMPTY) & clk_en, in_ready = (state!=FULL) & clk_en and out_data = main, with no combinational path from out_ready to in_ready.
REQ-015 SHALL, in EMPTY on an input transfer, load main with in_data and go to BUSY.
REQ-016 SHALL, in BUSY, apply these transitions:
- input and output transfer on the same edge: load main with in_data, stay in BUSY.
- input transfer only: load skid with in_data, go to FULL.
- output transfer only: go to EMPTY.
- neither: hold.
REQ-017 SHALL, in FULL on an output transfer, copy skid into main and go to BUSY; no input is accepted in FULL.
REQ-018 SHALL give a latency of exactly 1 cycle from an input transfer to out_valid when the stage was EMPTY.
REQ-019 SHALL sustain 1 transfer per cycle in steady state while out_ready=1.
REQ-020 SHALL preserve data order and never drop or duplicate a word under any out_ready pattern.
REQ-021 SHALL, with clk_en=0, leave state, main and skid unchanged and perform no transfers.
REQ-022 SHALL, with USE_REG=0, drive out_valid=in_valid, out_data=in_data and in_ready=out_ready combinationally; clk_en, clk and rst_n are then unused.
REQ-023 SHALL keep out_data unchanged while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL, on rst_n=0, immediately set state to EMPTY and main and skid to 0, regardless of clk or clk_en.
REQ-025 SHALL drive out_valid=0, in_ready=0 and out_data=0 while rst_n=0.
REQ-026 SHALL discard any held words when reset is asserted mid-operation.
REQ-027 SHALL accept input on the first clk edge after rst_n deasserts, provided clk_en=1.

Structure
REQ-028 SHALL take the state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the default LENGTH from the shared DSP package.
REQ-029 SHALL be a single module with no sub-modules; the USE_REG variants are selected by a generate block.

Verification
REQ-030 SHALL cover streaming: out_ready=1, inputs 1..8 on consecutive cycles -> outputs 1..8, each 1 cycle later, with in_ready=1 throughout.
REQ-031 SHALL cover backpressure: out_ready=0 while driving 5, 6, 7 -> 5 in main, 6 in skid, in_ready=0; 7 is held upstream; on out_ready=1 the outputs are 5, 6, 7 in order.
REQ-032 SHALL cover random stalls: 1000 random words with random in_valid/out_ready -> output sequence equals input sequence against a scoreboard.
REQ-033 SHALL cover enable freeze: FULL with 0x3FFFF/0x00001, clk_en=0 for 4 cycles with out_ready=1 -> no transfer, state kept; after clk_en=1 the outputs are 0x3FFFF, then 0x00001.
REQ-034 SHALL cover reset mid-operation: rst_n=0 between edges in FULL -> out_valid=0 and out_data=0 immediately; after release the next input appears first.
REQ-035 SHALL cover bypass: USE_REG=0, in_data=0x12345, out_ready=0 -> out_data=0x12345 in the same cycle and in_ready=0.
